// File: rtl/stack_ctrl.sv
// stack_ctrl: LIFO stack controller with a three-state handshake FSM.
// A request is accepted in IDLE. The following PUSH or POP cycle updates
// storage, the stack pointer and dout. Rejected requests pulse err.
// Status outputs are decoded from the registered stack pointer only.
module stack_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic                       ready,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2
    } state_t;

    // Storage is deliberately never reset.
    logic [WIDTH-1:0] mem [DEPTH];

    state_t           state_q,      state_d;
    logic [CW-1:0]    sp_q,         sp_d;
    logic [WIDTH-1:0] hold_q,       hold_d;
    logic [WIDTH-1:0] dout_q,       dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             err_q,        err_d;

    logic             mem_we_s;
    logic [AW-1:0]    wr_idx_s;
    logic [AW-1:0]    rd_idx_s;
    logic             full_s;
    logic             empty_s;

    // Decode status and memory indices from the registered stack pointer.
    always_comb begin
        full_s   = (sp_q == DEPTH_C);
        empty_s  = (sp_q == {CW{1'b0}});
        wr_idx_s = sp_q[AW-1:0];
        // When sp == DEPTH the low bits are zero and wrap to DEPTH-1.
        rd_idx_s = sp_q[AW-1:0] - AW'(1);
    end

    // Next-state logic: request arbitration in IDLE, one-cycle PUSH/POP.
    always_comb begin
        state_d      = state_q;
        sp_d         = sp_q;
        hold_d       = hold_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        err_d        = 1'b0;
        mem_we_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (push && pop) begin
                    err_d = 1'b1;
                end else if (push) begin
                    if (full_s) begin
                        err_d = 1'b1;
                    end else begin
                        hold_d  = din;
                        state_d = PUSH;
                    end
                end else if (pop) begin
                    if (empty_s) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = POP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PUSH: begin
                mem_we_s = 1'b1;
                sp_d     = sp_q + CW'(1);
                state_d  = IDLE;
            end
            POP: begin
                dout_d       = mem[rd_idx_s];
                sp_d         = sp_q - CW'(1);
                dout_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sp_q         <= {CW{1'b0}};
            hold_q       <= {WIDTH{1'b0}};
            dout_q       <= {WIDTH{1'b0}};
            dout_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sp_q         <= sp_d;
            hold_q       <= hold_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            err_q        <= err_d;
        end
    end

    // Storage write. A push aborted by reset may still write; the contents
    // are don't-care once sp has returned to zero.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[wr_idx_s] <= hold_q;
        end
    end

    assign ready      = (state_q == IDLE);
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign err        = err_q;
    assign count      = sp_q;
    assign full       = full_s;
    assign empty      = empty_s;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed testbench for stack_ctrl with a popped-word scoreboard.
module tb_stack_ctrl;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic             ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             err;

    int n_assert;
    int n_fail;
    int dv_count;
    int pops_done;

    logic [WIDTH-1:0] model_stack [$];
    logic [WIDTH-1:0] sb [$];

    stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .din        (din),
        .ready      (ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard compare on dout_valid, err/dout_valid exclusivity.
    always @(posedge clk) begin
        #1;
        chk("err_dv_excl", {31'd0, (err & dout_valid)}, 32'd0);
        if (dout_valid === 1'b1) begin
            dv_count++;
            if (sb.size() == 0) begin
                chk("unexpected_dv", 32'd1, 32'd0);
            end else begin
                chk("dout", {16'd0, dout}, {16'd0, sb.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [WIDTH-1:0] val);
        push = 1'b1;
        din  = val;
        tick();
        push = 1'b0;
        chk("ready_in_push", {31'd0, ready}, 32'd0);
        tick();
        model_stack.push_back(val);
        chk("count_after_push", {28'd0, count}, model_stack.size());
        chk("ready_after_push", {31'd0, ready}, 32'd1);
    endtask

    task automatic do_pop();
        sb.push_back(model_stack.pop_back());
        pops_done++;
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("ready_in_pop", {31'd0, ready}, 32'd0);
        chk("dv_early", {31'd0, dout_valid}, 32'd0);
        tick();
        chk("count_after_pop", {28'd0, count}, model_stack.size());
        chk("dv_pulse", {31'd0, dout_valid}, 32'd1);
        tick();
        chk("dv_single", {31'd0, dout_valid}, 32'd0);
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        dv_count  = 0;
        pops_done = 0;
        reset = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
        din   = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full",  {31'd0, full},  32'd0);
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_dout",  {16'd0, dout},  32'd0);
        chk("rst_err",   {31'd0, err},   32'd0);

        // Pop on empty is rejected
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("pop_empty_err",   {31'd0, err},   32'd1);
        chk("pop_empty_ready", {31'd0, ready}, 32'd1);
        chk("pop_empty_count", {28'd0, count}, 32'd0);
        tick();
        chk("pop_empty_err_single", {31'd0, err}, 32'd0);
        chk("pop_empty_dout", {16'd0, dout}, 32'd0);

        // Basic LIFO order
        do_push(16'h1111);
        do_push(16'h2222);
        do_push(16'h3333);
        chk("three_count", {28'd0, count}, 32'd3);
        do_pop();
        do_pop();
        do_pop();
        chk("lifo_count", {28'd0, count}, 32'd0);
        chk("lifo_empty", {31'd0, empty}, 32'd1);
        chk("lifo_dout_hold", {16'd0, dout}, 32'h1111);

        // Fill to DEPTH, then overflow push
        for (int i = 0; i < DEPTH; i++) begin
            do_push(16'hC000 + 16'(i * 3));
        end
        chk("full_flag",  {31'd0, full},  32'd1);
        chk("full_count", {28'd0, count}, DEPTH);
        push = 1'b1;
        din  = 16'hBEEF;
        tick();
        push = 1'b0;
        chk("ovf_err",   {31'd0, err},   32'd1);
        chk("ovf_count", {28'd0, count}, DEPTH);
        chk("ovf_ready", {31'd0, ready}, 32'd1);
        tick();
        chk("ovf_err_single", {31'd0, err}, 32'd0);
        while (model_stack.size() > 2) begin
            do_pop();
        end

        // Simultaneous push and pop at count=2
        push = 1'b1;
        pop  = 1'b1;
        din  = 16'h7777;
        tick();
        push = 1'b0;
        pop  = 1'b0;
        chk("both_err",   {31'd0, err},   32'd1);
        chk("both_count", {28'd0, count}, 32'd2);
        chk("both_ready", {31'd0, ready}, 32'd1);
        tick();

        // Push held high with incrementing din
        for (int i = 0; i < 6; i++) begin
            din  = 16'hA000 + 16'(i);
            push = 1'b1;
            chk("hold_ready", {31'd0, ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 0) begin
                model_stack.push_back(16'hA000 + 16'(i));
            end
            tick();
        end
        push = 1'b0;
        chk("hold_count", {28'd0, count}, 32'd5);
        do_pop();
        do_pop();
        do_pop();

        // Reset during a PUSH cycle at count=3
        do_push(16'h4444);
        chk("pre_rst_count", {28'd0, count}, 32'd3);
        push = 1'b1;
        din  = 16'h5555;
        tick();
        push  = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_stack.delete();
        chk("abort_count", {28'd0, count}, 32'd0);
        chk("abort_empty", {31'd0, empty}, 32'd1);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_dv",    {31'd0, dout_valid}, 32'd0);
        chk("abort_dout",  {16'd0, dout}, 32'd0);
        tick();
        chk("abort_count_stable", {28'd0, count}, 32'd0);

        // Scoreboard drained and one dout_valid pulse per pop
        tick();
        chk("sb_drained", sb.size(), 32'd0);
        chk("dv_total", dv_count, pops_done);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: number of stack entries; legal values are 2, 4, 8 and 16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port push, input, 1 bit: push request, sampled only while ready=1.
REQ-006 SHALL have port pop, input, 1 bit: pop request, sampled only while ready=1.
REQ-007 SHALL have port din, input, WIDTH bits: push data, captured in the same cycle push is accepted.
REQ-008 SHALL have port ready, output, 1 bit: controller is in IDLE and can accept a request.
REQ-009 SHALL have port dout, output, WIDTH bits: popped word, registered.
REQ-010 SHALL have port dout_valid, output, 1 bit: one-cycle pulse marking dout as new.
REQ-011 SHALL have port count, output, clog2(DEPTH)+1 bits: number of occupied entries, 0..DEPTH.
REQ-012 SHALL have port full, output, 1 bit: count==DEPTH.
REQ-013 SHALL have port empty, output, 1 bit: count==0.
REQ-014 SHALL have port err, output, 1 bit: one-cycle pulse marking a rejected request.

Function
REQ-015 SHALL contain DEPTH x WIDTH storage plus a stack-pointer register (sp = count); sp is the index of the next free entry.
REQ-016 SHALL implement an FSM with states IDLE, PUSH and POP; ready=1 only in IDLE.
REQ-017 In IDLE, when push=1, pop=0 and full=0, SHALL latch din into a holding register and go to PUSH.
REQ-018 In IDLE, when pop=1, push=0 and empty=0, SHALL go to POP.
REQ-019 In IDLE, SHALL reject the request, pulse err for one cycle and stay in IDLE with storage, sp and dout unchanged, in each of these cases:
- push=1 and pop=1;
- push=1 with full=1;
- pop=1 with empty=1.
REQ-020 In IDLE, when push=0 and pop=0, SHALL stay in IDLE with no state change.
REQ-021 In PUSH, SHALL write the held word to mem[sp], set sp<=sp+1 and return to IDLE; the duration is exactly one cycle.
REQ-022 In POP, SHALL set dout<=mem[sp-1] and sp<=sp-1, assert dout_valid for the following cycle only, and return to IDLE; the duration is exactly one cycle.
REQ-023 Accept-to-completion latency: for a request accepted at edge N, storage/sp update at edge N+1, and count/full/empty/dout_valid reflect it in the cycle after edge N+1.
REQ-024 Request throughput: one accepted request every 2 cycles maximum.
REQ-025 push and pop inputs SHALL be ignored while ready=0, with no err.
REQ-026 sp SHALL never wrap: it SHALL never exceed DEPTH nor go below 0.
REQ-027 sp arithmetic SHALL be unsigned clog2(DEPTH)+1 bits, increment/decrement by exactly 1.
REQ-028 dout SHALL hold its last popped value until the next pop completes.
REQ-029 full, empty and count SHALL be decoded from the registered sp, with no combinational path from push/pop/din.
REQ-030 err and dout_valid SHALL never be asserted in the same cycle.

Reset
REQ-031 With reset=1 at a rising edge: state<=IDLE, sp<=0, dout<=0, dout_valid<=0, err<=0; consequently ready=1, empty=1, full=0, count=0.
REQ-032 Reset SHALL take priority over every request and SHALL abort a PUSH or POP in progress; an aborted push leaves sp=0 and the contents of storage don't-care.
REQ-033 Storage contents SHALL NOT be cleared by reset.

Verification
REQ-034 Reset, then push 0x1111, 0x2222, 0x3333 (one per ready cycle), then pop three times -> dout sequence 0x3333, 0x2222, 0x1111, each with a single dout_valid pulse; count ends at 0 and empty=1.
REQ-035 Push DEPTH words, then push 0xBEEF -> full=1, count=DEPTH, one err pulse, count unchanged; the next pop returns the last legal word.
REQ-036 Pop after reset -> one err pulse, dout stays 0x0000, no dout_valid pulse.
REQ-037 push=1 and pop=1 together in IDLE with count=2 -> one err pulse, count stays 2, ready stays 1.
REQ-038 Hold push=1 continuously with din incrementing every cycle -> only words present in ready cycles are stored, and ready toggles 1,0,1,0.
REQ-039 Assert reset during the PUSH cycle with count=3 -> next cycle count=0, empty=1, ready=1, dout_valid=0.
